fsm_req_client: RTL and testbench
=================================

Name: fsm_req_client

Overview:
- Requester-side counterpart to the team's 4-way req/gnt grant arbiter.
- Four independent channels each accept a burst command, raise req_N, wait for gnt_N, hold the grant for the commanded number of beats, then release and wait for the arbiter to withdraw the grant.
- Sits between local command sources and the arbiter's req_0..3/gnt_0..3 pins.

Parameters:
- LEN_W, 4, width of cmd_len per channel.
- TIMEOUT, 16, max cycles in REQ without gnt before abort (must be >=3).
- TO_W, 5, wait-counter width (must hold TIMEOUT).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  4  per-channel command valid, bit N = channel N.
- cmd_len  in  4*LEN_W  beat counts; channel N in bits [N*LEN_W +: LEN_W].
- cmd_ready  out  4  channel N idle and accepting.
- req_0..req_3  out  1 each  registered requests to the arbiter.
- gnt_0..gnt_3  in  1 each  grants from the arbiter.
- xfer  out  4  channel N is in a granted beat this cycle.
- done  out  4  1-cycle pulse: burst completed cleanly.
- err  out  4  1-cycle pulse: timeout or grant lost mid-burst.
- proto_err  out  1  sticky: grant seen on a channel that is not requesting.

Behaviour:
- Reset is synchronous and active-high on clock. It dominates all else.
  - All channels go to IDLE.
  - req_*, xfer, done, err, proto_err = 0.
  - cmd_ready = 4'b1111 from the first cycle after reset.
  - Reset mid-burst drops req on the next edge, with no done or err pulse.
- All outputs are registered. cmd_ready, req_N and xfer are decoded from the registered state.
- Per-channel FSM: IDLE -> REQ -> XFER -> RELEASE -> IDLE.
- IDLE:
  - cmd_ready=1, req=0.
  - cmd_valid & cmd_ready at an edge latches beats = (cmd_len==0 ? 1 : cmd_len), clears wait_cnt, and goes to REQ.
  - req is high in the cycle right after acceptance.
- REQ:
  - req=1. wait_cnt increments each cycle gnt is low.
  - gnt=1 at an edge -> XFER with beat_cnt=beats.
  - wait_cnt==TIMEOUT-1 with gnt still low -> err pulse, RELEASE. This takes priority only when gnt=0.
- XFER:
  - req=1 and xfer=1 while gnt=1.
  - Each edge with gnt=1 decrements beat_cnt.
  - Last beat (beat_cnt==1): req goes low at that edge -> RELEASE.
  - gnt=0 while in XFER is a lost grant: err pulse, RELEASE, no done.
- RELEASE:
  - req=0.
  - Exits to IDLE after gnt has been low for 2 consecutive cycles. This covers the arbiter's 2-cycle req-to-gnt pipeline, including a late grant after a timeout.
  - done pulses on the IDLE entry edge only if no err was raised for this burst.
  - cmd_ready rises with the IDLE entry, so back-to-back commands see at least 1 idle cycle between bursts.
- proto_err:
  - Set when gnt_N=1 while channel N is in IDLE.
  - Also set when more than one gnt is high in the same cycle.
  - Cleared only by reset.
- Channels are fully independent.
  - Simultaneous commands on all four channels are all accepted in the same cycle.
  - Arbitration order is the arbiter's concern, not this block's.
- Counters saturate and never wrap. beat_cnt is LEN_W bits and wait_cnt is TO_W bits.

Decomposition:
- Shared package fsm_req_pkg holds:
  - the state enum (IDLE=2'd0, REQ=2'd1, XFER=2'd2, RELEASE=2'd3);
  - the RELEASE_GAP=2 constant.
- One sub-module, fsm_req_chan (single-channel FSM plus counters), instantiated 4x.
- The top does cmd_len slicing, req/gnt scalar mapping and proto_err.

Test Plan:
- Reset, then channel 0 gets cmd_len=3 and the bench grants gnt_0 2 cycles after req_0 rises -> xfer[0] high exactly 3 cycles, req_0 low after the 3rd beat, done[0] pulses 2 cycles after gnt_0 falls, cmd_ready[0] returns 1.
- Channel 2 gets cmd_len=0 -> treated as 1 beat: single xfer[2] cycle, then done[2].
- Channel 1 requests and gnt_1 never asserts -> err[1] pulses after 16 cycles in REQ, req_1 falls, no done[1], channel back in IDLE 2 cycles later.
- Channel 3 with cmd_len=5, gnt_3 dropped after beat 2 -> err[3], req_3 low next edge, xfer[3] total 2 cycles.
- All four channels commanded together and the bench grants them serially (0,1,2,3) -> each completes with its own done, and no req drops before its grant.
- gnt_2 pulsed while channel 2 is IDLE -> proto_err=1 and stays 1 until reset. Also assert reset during channel 0 XFER -> req_0=0 next cycle, with no done or err.

Source files
------------

// File: rtl/fsm_req_pkg.sv
// Shared definitions for the requester-side req/gnt client.
package fsm_req_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } chan_state_e;

    // Arbiter req-to-gnt pipeline depth; grant must stay low this long before reuse.
    localparam int unsigned RELEASE_GAP = 2;

endpackage

// File: rtl/fsm_req_chan.sv
// One requester channel: accepts a burst, requests, holds the grant for N beats,
// then waits for the arbiter to withdraw the grant.
module fsm_req_chan
    import fsm_req_pkg::*;
#(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             gnt,
    output logic             cmd_ready,
    output logic             req,
    output logic             xfer,
    output logic             done,
    output logic             err
);

    localparam logic [TO_W-1:0]  WAIT_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  WAIT_MAX  = '1;
    localparam logic [LEN_W-1:0] ONE_BEAT  = LEN_W'(1);
    localparam logic [1:0]       GAP_LAST  = 2'(RELEASE_GAP - 1);

    chan_state_e      state;
    logic [LEN_W-1:0] beats;
    logic [LEN_W-1:0] beat_cnt;
    logic [TO_W-1:0]  wait_cnt;
    logic [1:0]       gap_cnt;
    logic             err_seen;

    assign cmd_ready = (state == IDLE);
    assign req       = (state == REQ) || (state == XFER);
    // A beat only happens while the arbiter is actually granting.
    assign xfer      = (state == XFER) && gnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            beats    <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            err_seen <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        beats    <= (cmd_len == '0) ? ONE_BEAT : cmd_len;
                        wait_cnt <= '0;
                        err_seen <= 1'b0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (gnt) begin
                        beat_cnt <= beats;
                        state    <= XFER;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err      <= 1'b1;
                        err_seen <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= RELEASE;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                XFER: begin
                    if (!gnt) begin
                        err      <= 1'b1;
                        err_seen <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= RELEASE;
                    end else begin
                        if (beat_cnt != '0) beat_cnt <= beat_cnt - ONE_BEAT;
                        if (beat_cnt <= ONE_BEAT) begin
                            gap_cnt <= '0;
                            state   <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    // Any grant seen restarts the quiet window (covers a late grant after timeout).
                    if (gnt) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        done  <= !err_seen;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fsm_req_client.sv
// Four independent requester channels facing the 4-way req/gnt arbiter,
// plus a sticky protocol-violation flag for unexpected or overlapping grants.
module fsm_req_client
    import fsm_req_pkg::*;
#(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         cmd_valid,
    input  logic [4*LEN_W-1:0] cmd_len,
    output logic [3:0]         cmd_ready,
    output logic               req_0,
    output logic               req_1,
    output logic               req_2,
    output logic               req_3,
    input  logic               gnt_0,
    input  logic               gnt_1,
    input  logic               gnt_2,
    input  logic               gnt_3,
    output logic [3:0]         xfer,
    output logic [3:0]         done,
    output logic [3:0]         err,
    output logic               proto_err
);

    logic [3:0] gnt_vec;
    logic [3:0] req_vec;
    logic       gnt_idle;
    logic       gnt_multi;

    assign gnt_vec = {gnt_3, gnt_2, gnt_1, gnt_0};
    assign req_0   = req_vec[0];
    assign req_1   = req_vec[1];
    assign req_2   = req_vec[2];
    assign req_3   = req_vec[3];

    for (genvar n = 0; n < 4; n++) begin : g_chan
        fsm_req_chan #(
            .LEN_W  (LEN_W),
            .TIMEOUT(TIMEOUT),
            .TO_W   (TO_W)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .cmd_valid(cmd_valid[n]),
            .cmd_len  (cmd_len[n*LEN_W +: LEN_W]),
            .gnt      (gnt_vec[n]),
            .cmd_ready(cmd_ready[n]),
            .req      (req_vec[n]),
            .xfer     (xfer[n]),
            .done     (done[n]),
            .err      (err[n])
        );
    end

    assign gnt_idle  = |(gnt_vec & cmd_ready);
    // Clearing the lowest set bit leaves something only if two or more grants are high.
    assign gnt_multi = (gnt_vec & (gnt_vec - 4'd1)) != '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (gnt_idle || gnt_multi) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fsm_req_client.sv
// Directed bench for fsm_req_client: per-cycle vector table plus hand-written
// multi-cycle sequences for timeout, lost grant, serial grants and reset.
module tb_fsm_req_client;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  cmd_valid;
    logic [15:0] cmd_len;
    logic [3:0]  cmd_ready;
    logic        req_0, req_1, req_2, req_3;
    logic        gnt_0, gnt_1, gnt_2, gnt_3;
    logic [3:0]  xfer, done, err;
    logic        proto_err;
    logic [3:0]  req_vec;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;
    assign req_vec = {req_3, req_2, req_1, req_0};

    fsm_req_client #(.LEN_W(4), .TIMEOUT(16), .TO_W(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_len  (cmd_len),
        .cmd_ready(cmd_ready),
        .req_0    (req_0),
        .req_1    (req_1),
        .req_2    (req_2),
        .req_3    (req_3),
        .gnt_0    (gnt_0),
        .gnt_1    (gnt_1),
        .gnt_2    (gnt_2),
        .gnt_3    (gnt_3),
        .xfer     (xfer),
        .done     (done),
        .err      (err),
        .proto_err(proto_err)
    );

    typedef struct {
        logic [3:0]  cv;
        logic [15:0] len;
        logic [3:0]  gnt;
        logic [3:0]  rdy;
        logic [3:0]  req;
        logic [3:0]  xf;
        logic [3:0]  dn;
        logic [3:0]  er;
        logic        pe;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] cv, input logic [15:0] len, input logic [3:0] gnt,
                       input logic [3:0] rdy, input logic [3:0] rq, input logic [3:0] xf,
                       input logic [3:0] dn, input logic [3:0] er, input logic pe);
        vec_t v;
        v.cv = cv; v.len = len; v.gnt = gnt;
        v.rdy = rdy; v.req = rq; v.xf = xf; v.dn = dn; v.er = er; v.pe = pe;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_gnt(input logic [3:0] g);
        {gnt_3, gnt_2, gnt_1, gnt_0} = g;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         xc;
        logic       dseen;
        logic [3:0] pend;
        logic [3:0] dn_acc;
        logic [3:0] er_acc;
        bit         g3[8];
        int         exp_beats[4];

        reset = 1'b1;
        cmd_valid = '0;
        cmd_len = '0;
        set_gnt(4'h0);
        repeat (3) @(posedge clock);

        // cols: cv len gnt | rdy req xfer done err perr
        add(4'h0, 16'h0000, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h1, 16'h0003, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h1, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h1, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h1, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h1, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        // channel 2, zero length -> one beat
        add(4'h4, 16'h0000, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hB, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h4, 4'hB, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h4, 4'hB, 4'h4, 4'h4, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hF, 4'h0, 4'h0, 4'h4, 4'h0, 1'b0);
        add(4'h0, 16'h0000, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clock);
            reset = 1'b0;
            cmd_valid = vecs[i].cv;
            cmd_len = vecs[i].len;
            set_gnt(vecs[i].gnt);
            #1;
            chk($sformatf("vec[%0d] rdy_req_xfer_done_err_perr", i),
                {cmd_ready, req_vec, xfer, done, err, proto_err},
                {vecs[i].rdy, vecs[i].req, vecs[i].xf, vecs[i].dn, vecs[i].er, vecs[i].pe});
        end

        // Channel 1 timeout: no grant ever
        @(negedge clock);
        cmd_valid = 4'h2;
        cmd_len = 16'h0020;
        @(negedge clock);
        cmd_valid = 4'h0;
        #1;
        n = 0;
        while (req_1 && n < 40) begin
            n++;
            @(negedge clock);
            #1;
        end
        chk("timeout_req_cycles", n, 16);
        chk("timeout_err_pulse", err[1], 1'b1);
        chk("timeout_no_done", done[1], 1'b0);
        @(negedge clock);
        #1;
        chk("timeout_err_once_still_busy", {err[1], cmd_ready[1]}, 2'b00);
        @(negedge clock);
        #1;
        chk("timeout_idle_no_done", {cmd_ready[1], done[1]}, 2'b10);

        // Channel 3 lost grant after two beats
        g3 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        @(negedge clock);
        cmd_valid = 4'h8;
        cmd_len = 16'h5000;
        xc = 0;
        dseen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            cmd_valid = 4'h0;
            gnt_3 = g3[i];
            #1;
            if (xfer[3]) xc++;
            if (done[3]) dseen = 1'b1;
            if (i == 4) chk("lost_req_held", req_3, 1'b1);
            if (i == 5) chk("lost_req_drop_err", {req_3, err[3]}, 2'b01);
            if (i == 7) chk("lost_back_idle", cmd_ready[3], 1'b1);
        end
        chk("lost_xfer_count", xc, 2);
        chk("lost_no_done", dseen, 1'b0);

        // All four at once, granted serially
        exp_beats = '{2, 1, 3, 1};
        dn_acc = '0;
        er_acc = '0;
        @(negedge clock);
        cmd_valid = 4'hF;
        cmd_len = 16'h0312;
        for (int ch = 0; ch < 4; ch++) begin
            @(negedge clock);
            cmd_valid = 4'h0;
            set_gnt(4'h1 << ch);
            #1;
            dn_acc |= done;
            er_acc |= err;
            pend = 4'hF << ch;
            chk($sformatf("serial_pending_req[%0d]", ch), req_vec & pend, pend);
            xc = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clock);
                #1;
                dn_acc |= done;
                er_acc |= err;
                if (!xfer[ch]) break;
                xc++;
            end
            set_gnt(4'h0);
            chk($sformatf("serial_beats[%0d]", ch), xc, exp_beats[ch]);
        end
        repeat (4) begin
            @(negedge clock);
            #1;
            dn_acc |= done;
            er_acc |= err;
        end
        chk("serial_all_done", dn_acc, 4'hF);
        chk("serial_no_err", er_acc, 4'h0);
        chk("serial_no_proto", proto_err, 1'b0);
        chk("serial_all_ready", cmd_ready, 4'hF);

        // Grant on an idle channel is a sticky protocol error
        @(negedge clock);
        gnt_2 = 1'b1;
        #1;
        chk("proto_not_yet", proto_err, 1'b0);
        @(negedge clock);
        gnt_2 = 1'b0;
        #1;
        chk("proto_set", proto_err, 1'b1);
        repeat (5) @(negedge clock);
        #1;
        chk("proto_sticky", proto_err, 1'b1);

        // Reset during channel 0 XFER
        @(negedge clock);
        cmd_valid = 4'h1;
        cmd_len = 16'h0004;
        @(negedge clock);
        cmd_valid = 4'h0;
        gnt_0 = 1'b1;
        @(negedge clock);
        #1;
        chk("rst_in_xfer", xfer[0], 1'b1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_before_edge", req_0, 1'b1);
        @(negedge clock);
        gnt_0 = 1'b0;
        #1;
        chk("rst_req_drop", {req_0, xfer[0], done[0], err[0], proto_err}, 5'b0);
        @(negedge clock);
        reset = 1'b0;
        dn_acc = '0;
        er_acc = '0;
        repeat (4) begin
            @(negedge clock);
            #1;
            dn_acc |= done;
            er_acc |= err;
        end
        chk("rst_no_pulses", {dn_acc, er_acc}, 8'h00);
        chk("rst_ready", cmd_ready, 4'hF);

        // Two grants in the same cycle
        @(negedge clock);
        cmd_valid = 4'h3;
        cmd_len = 16'h0011;
        @(negedge clock);
        cmd_valid = 4'h0;
        set_gnt(4'h3);
        #1;
        chk("multi_before", proto_err, 1'b0);
        @(negedge clock);
        set_gnt(4'h0);
        #1;
        chk("multi_proto", proto_err, 1'b1);
        repeat (4) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
